// File: rtl/pb_uart_rx_pkg.sv
// Shared types and helpers for the simulation-side UART receive monitor.
// Optional feature macro: PB_UART_RX_PARITY_EN (even parity bit, 8E1 framing).
package pb_uart_rx_pkg;

    localparam int DataBits = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    // Width of the per-bit sample counter; never narrower than one bit.
    function automatic int clk_cnt_w(input int clkPerBit);
        if (clkPerBit <= 2) begin
            return 1;
        end
        return $clog2(clkPerBit);
    endfunction

endpackage

// File: rtl/pb_uart_rx_monitor_if.sv
// Byte handshake between the UART receive monitor and the bench console printer.
// The monitor drives the head byte and its valid flag; the printer answers with ready.
interface pb_uart_rx_monitor_if;
    import pb_uart_rx_pkg::*;

    logic [DataBits-1:0] byte_o;
    logic                byte_valid_o;
    logic                byte_ready_i;

    modport master (
        output byte_o,
        output byte_valid_o,
        input  byte_ready_i
    );

    modport slave (
        input  byte_o,
        input  byte_valid_o,
        output byte_ready_i
    );

endinterface

// File: rtl/pb_uart_rx_fifo.sv
// Small synchronous receive FIFO with a sticky overflow flag.
// A clear in the same cycle as a push leaves only the pushed byte in the FIFO.
module pb_uart_rx_fifo #(
    parameter int Depth = 8,
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic             overflow_o
);

    localparam int PtrW = $clog2(Depth);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
    logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full;
    logic             doPop;
    logic             doPush;
    logic             writeEn;
    logic [PtrW-1:0]  writeAddr;

    // Decide which pushes/pops are accepted and compute the next pointer/count/overflow values.
    always_comb begin
        full      = (count_q == DepthCnt);
        doPop     = pop_i && (count_q != '0);
        doPush    = push_i && (!full || doPop);
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        overflow_d = overflow_q;
        writeEn   = doPush;
        writeAddr = wrPtr_q;
        if (clear_i) begin
            writeEn    = push_i;
            writeAddr  = '0;
            wrPtr_d    = push_i ? PtrW'(1) : '0;
            rdPtr_d    = '0;
            count_d    = push_i ? (PtrW + 1)'(1) : '0;
            overflow_d = 1'b0;
        end else begin
            wrPtr_d    = wrPtr_q + PtrW'(doPush);
            rdPtr_d    = rdPtr_q + PtrW'(doPop);
            count_d    = count_q + (PtrW + 1)'(doPush) - (PtrW + 1)'(doPop);
            overflow_d = overflow_q | (push_i && !doPush);
        end
    end

    // Pointer, occupancy and overflow registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are only visible through data_o while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (writeEn) begin
            mem_q[writeAddr] <= data_i;
        end
    end

    assign valid_o    = (count_q != '0);
    assign data_o     = valid_o ? mem_q[rdPtr_q] : '0;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/pb_uart_rx_monitor.sv
// Simulation-side UART receiver: synchronizes rx_i, deframes bytes and buffers them in a FIFO.
// Optional feature macro: PB_UART_RX_PARITY_EN adds an even parity bit (11 bit periods per frame).
module pb_uart_rx_monitor
    import pb_uart_rx_pkg::*;
#(
    parameter int ClkPerBit = 16,
    parameter int FifoDepth = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        rx_i,
    input  logic                        clear_i,
    pb_uart_rx_monitor_if.master        byte_if,
    output logic                        reading_byte_o,
    output logic                        frame_err_o,
    output logic                        overflow_o
);

    localparam int CntW = clk_cnt_w(ClkPerBit);
    localparam logic [CntW-1:0] HalfCnt = CntW'(ClkPerBit / 2);
    localparam logic [CntW-1:0] LastCnt = CntW'(ClkPerBit - 1);

    if (ClkPerBit < 4) begin : gBadClkPerBit
        $fatal(1, "pb_uart_rx_monitor: ClkPerBit must be at least 4");
    end
    if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : gBadFifoDepth
        $fatal(1, "pb_uart_rx_monitor: FifoDepth must be a power of two and at least 2");
    end

    rx_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2:0]            bitIdx_q, bitIdx_d;
    logic [DataBits-1:0]   shift_q, shift_d;
    logic                  frameErr_q, frameErr_d;
    logic                  rxMeta_q, rxSync_q, rxPrev_q;
    logic                  pushByte;
`ifdef PB_UART_RX_PARITY_EN
    logic                  parityErr_q, parityErr_d;
`endif

    // Two-flop synchronizer for the asynchronous line plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx_i;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // Receiver state, sample counter, bit index, shift register and error flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            frameErr_q  <= 1'b0;
`ifdef PB_UART_RX_PARITY_EN
            parityErr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            frameErr_q  <= frameErr_d;
`ifdef PB_UART_RX_PARITY_EN
            parityErr_q <= parityErr_d;
`endif
        end
    end

    // Frame sequencing: mid-bit sampling, LSB-first shifting and stop-bit validation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        frameErr_d  = 1'b0;
        pushByte    = 1'b0;
`ifdef PB_UART_RX_PARITY_EN
        parityErr_d = parityErr_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rxPrev_q && !rxSync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HalfCnt) begin
                    if (rxSync_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        cnt_d    = '0;
                        bitIdx_d = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == LastCnt) begin
                    shift_d  = {rxSync_q, shift_q[DataBits-1:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
`ifdef PB_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef PB_UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == LastCnt) begin
                    parityErr_d = rxSync_q ^ (^shift_q);
                    state_d     = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == LastCnt) begin
`ifdef PB_UART_RX_PARITY_EN
                    if (rxSync_q && !parityErr_q) begin
`else
                    if (rxSync_q) begin
`endif
                        pushByte = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                    state_d = rxSync_q ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    pb_uart_rx_fifo #(
        .Depth (FifoDepth),
        .Width (DataBits)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .push_i     (pushByte),
        .data_i     (shift_q),
        .pop_i      (byte_if.byte_ready_i),
        .data_o     (byte_if.byte_o),
        .valid_o    (byte_if.byte_valid_o),
        .overflow_o (overflow_o)
    );

    assign reading_byte_o = (state_q != IDLE) && (state_d != IDLE);
    assign frame_err_o    = frameErr_q;

endmodule
